// File: rtl/bk_mem_arbiter.sv
`timescale 1ns/1ps
// bk_mem_arbiter: shares one RAM port between video fetch, disk DMA and CPU.
// Fixed priority video > DMA > CPU. The CPU is guaranteed a slot after a run
// of DMA_BURST DMA grants.
// Optional build macro ARB_WAITCNT_EN adds the wait_clr input and the
// cpu_wait_max output (longest CPU wait in cycles, saturating at 255).
//
// state  | meaning
// IDLE   | evaluate requests, latch winner and its access
// ISSUE  | one cycle of mem_we or mem_rd
// RWAIT  | count down read latency, capture mem_dout at zero
// DONE   | one-cycle ack to the winner
module bk_mem_arbiter #(
  parameter int AW        = 25,
  parameter int DW        = 16,
  parameter int RD_LAT    = 2,
  parameter int DMA_BURST = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic          dma_ack,
  output logic [DW-1:0] dma_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic [1:0]    mem_be,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
`ifdef ARB_WAITCNT_EN
  ,
  input  logic          wait_clr,
  output logic [7:0]    cpu_wait_max
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RWAIT, S_DONE} state_e;
  typedef enum logic [1:0] {W_VID, W_DMA, W_CPU} win_e;

  localparam logic [3:0] BURST   = 4'(DMA_BURST);
  localparam logic [2:0] LAT_TOP = 3'(RD_LAT - 1);

  state_e        state_q, state_d;
  win_e          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    be_q, be_d;
  logic [2:0]    lat_q, lat_d;
  logic [3:0]    run_q, run_d;
  logic          cap;
  logic [DW-1:0] vid_data_q, dma_dout_q, cpu_dout_q;

  // Next-state, grant selection and DMA run accounting.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    be_d    = be_q;
    lat_d   = lat_q;
    run_d   = run_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vid_req) begin
          win_d   = W_VID;
          we_d    = 1'b0;
          addr_d  = vid_addr;
          be_d    = 2'b11;
          state_d = S_ISSUE;
          if (!dma_req) run_d = 4'd0;
        end else if (dma_req && !(cpu_req && run_q == BURST)) begin
          win_d   = W_DMA;
          we_d    = dma_we;
          addr_d  = dma_addr;
          be_d    = 2'b11;
          if (dma_we) din_d = dma_din;
          state_d = S_ISSUE;
          run_d   = (run_q >= BURST) ? BURST : run_q + 4'd1;
        end else if (cpu_req) begin
          win_d   = W_CPU;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          be_d    = cpu_be;
          if (cpu_we) din_d = cpu_din;
          state_d = S_ISSUE;
          run_d   = 4'd0;
        end else begin
          run_d   = 4'd0;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RWAIT;
          lat_d   = LAT_TOP;
        end
      end
      S_RWAIT: begin
        if (lat_q == 3'd0) begin
          cap     = 1'b1;
          state_d = S_DONE;
        end else begin
          lat_d   = lat_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-access registers; address/data/be double as RAM port outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      win_q   <= W_VID;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= 2'b00;
      lat_q   <= 3'd0;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      lat_q   <= lat_d;
      run_q   <= run_d;
    end
  end

  // Read data capture into the winner's hold register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vid_data_q <= '0;
      dma_dout_q <= '0;
      cpu_dout_q <= '0;
    end else if (cap) begin
      case (win_q)
        W_VID:   vid_data_q <= mem_dout;
        W_DMA:   dma_dout_q <= mem_dout;
        default: cpu_dout_q <= mem_dout;
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_be   = be_q;
  assign mem_we   = (state_q == S_ISSUE) && we_q;
  assign mem_rd   = (state_q == S_ISSUE) && !we_q;
  assign busy     = (state_q != S_IDLE);
  assign vid_ack  = (state_q == S_DONE) && (win_q == W_VID);
  assign dma_ack  = (state_q == S_DONE) && (win_q == W_DMA);
  assign cpu_ack  = (state_q == S_DONE) && (win_q == W_CPU);
  assign vid_data = vid_data_q;
  assign dma_dout = dma_dout_q;
  assign cpu_dout = cpu_dout_q;

`ifdef ARB_WAITCNT_EN
  logic [7:0] wcnt_q, wcnt_d, wmax_q;

  // Current CPU wait length: counts pending cycles, clears on completion.
  always_comb begin
    wcnt_d = wcnt_q;
    if (cpu_ack)
      wcnt_d = 8'd0;
    else if (cpu_req && wcnt_q != 8'hff)
      wcnt_d = wcnt_q + 8'd1;
  end

  // Wait counter and running maximum.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q <= 8'd0;
      wmax_q <= 8'd0;
    end else begin
      wcnt_q <= wcnt_d;
      if (wait_clr)
        wmax_q <= 8'd0;
      else if (wcnt_d > wmax_q)
        wmax_q <= wcnt_d;
    end
  end

  assign cpu_wait_max = wmax_q;
`endif

endmodule

// File: doc/bk_mem_arbiter.md
Name: bk_mem_arbiter

Overview:
- Shares the single system RAM port between three requesters: the video scan-out fetch, the disk-copy DMA engine, and the CPU bus.
- Sequences each access as address issue, then write completion or read-latency wait, then a one-cycle acknowledge to the winning requester.
- Priority is fixed (video > DMA > CPU), with an anti-starvation rule that guarantees the CPU a slot after a bounded DMA run.
- Sits between the CPU/DMA/video fronts and the RAM primitive inside the memory subsystem.

Parameters:
- AW, 25: address width, shared by all requesters and the RAM port.
- DW, 16: data width.
- RD_LAT, 2: cycles from the mem_rd issue cycle to valid mem_dout. Legal range 1..7.
- DMA_BURST, 4: maximum consecutive DMA grants while cpu_req is pending. Legal range 1..15.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  video read request; level, held until vid_ack
- vid_addr  in  AW  video read address
- vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle
- vid_data  out  DW  video read data
- dma_req  in  1  DMA request; level, held until dma_ack
- dma_we  in  1  DMA write (1) or read (0)
- dma_addr  in  AW  DMA address
- dma_din  in  DW  DMA write data
- dma_ack  out  1  one-cycle completion pulse
- dma_dout  out  DW  DMA read data
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  CPU write (1) or read (0)
- cpu_be  in  2  CPU byte enables for writes (wtbt style)
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_dout  out  DW  CPU read data
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_be  out  2  RAM byte enables
- mem_we  out  1  RAM write strobe, one cycle
- mem_rd  out  1  RAM read strobe, one cycle
- mem_dout  in  DW  RAM read data
- busy  out  1  high while any access is in flight

Behaviour:
- Reset:
  - State is IDLE.
  - All acks, mem_we, mem_rd and busy are 0.
  - All data and address outputs are 0.
  - The DMA run counter is 0.
- FSM states: IDLE, ISSUE, RWAIT, DONE.
- IDLE: evaluate requests every cycle. If any request is present:
  - latch the winner id, address, data, byte enables and direction;
  - go to ISSUE; busy=1 from the next cycle.
- Winner selection:
  - vid_req wins first.
  - Otherwise dma_req wins, unless cpu_req is high and run==DMA_BURST, in which case the CPU wins.
  - Otherwise cpu_req wins.
- Video accesses are always reads with mem_be=2'b11.
- DMA accesses always use mem_be=2'b11.
- ISSUE, for exactly one cycle:
  - drive mem_addr;
  - for a write: mem_we=1 and mem_din/mem_be driven, then go to DONE;
  - for a read: mem_rd=1, then go to RWAIT with the latency counter set to RD_LAT-1.
- RWAIT:
  - decrement the counter each cycle;
  - when it reaches 0, capture mem_dout into the winner's dout register and go to DONE;
  - with RD_LAT=1, capture happens on the first RWAIT cycle.
- DONE:
  - pulse the winner's ack for one cycle;
  - the dout register holds its value until that requester's next read completes;
  - return to IDLE; busy=0 in the IDLE cycle.
- Access latency: a write acks 2 cycles after the request is sampled in IDLE. A read acks RD_LAT+2 cycles after.
- Idle turnaround: IDLE costs one cycle per access, so back-to-back requests are spaced RD_LAT+3 cycles (reads) or 3 cycles (writes).
- Run counter:
  - increments on each DMA grant, saturating at DMA_BURST;
  - clears on any CPU grant, and on any IDLE cycle with dma_req=0.
  - Video grants do not change it.
- A request dropped before its ack is a requester protocol violation. The arbiter still completes the latched access and pulses ack.
- mem_addr, mem_din and mem_be hold their last values outside ISSUE.
- Asynchronous reset mid-access: abort immediately, with no ack and no strobes. A latched access is not replayed.

Optional Feature:
- Macro: ARB_WAITCNT_EN.
- When defined, the block adds output cpu_wait_max [7:0]:
  - a wait counter counts cycles while cpu_req=1 and cpu_ack has not yet pulsed, saturating at 255;
  - the counter clears on cpu_ack;
  - cpu_wait_max holds the largest count observed;
  - cpu_wait_max resets to 0 via reset_n, or via input wait_clr (1 bit, synchronous), which is also added.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
- Single CPU write: addr 0x1000, din 0xA5A5, be 2'b01 -> mem_we for one cycle with those values, cpu_ack 2 cycles after the request; no other ack fires.
- CPU read with RD_LAT=2, memory returning 0x1234 -> mem_rd for one cycle, cpu_ack 4 cycles after the request, cpu_dout=0x1234 and held after the ack.
- vid_req, dma_req and cpu_req asserted in the same cycle -> grant order video, DMA, CPU; exactly one ack per access; busy continuous with 1-cycle IDLE gaps.
- dma_req and cpu_req held continuously, DMA_BURST=4 -> grant pattern D,D,D,D,C,D,D,D,D,C; the CPU is never skipped more than 4 times.
- reset_n pulsed low during RWAIT of a DMA read -> all outputs 0 immediately, no dma_ack; after release, the next request is serviced normally.
- With ARB_WAITCNT_EN: CPU blocked behind 3 DMA writes -> cpu_wait_max=11 (9 cycles queued behind the DMA writes plus 2 for its own write); wait_clr -> 0.
